ahb_arbiter: RTL and testbench



---
 rtl/ahb_arbiter_if.sv | 26 ++
 rtl/ahb_arbiter.sv | 112 +++++++++++
 tb/tb_ahb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// Arbitration bundle between the bus masters, the slave ready and the arbiter.
// Latency: none, wires only.
// Backpressure: hready from the slaves stalls every arbitration decision.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [1:0]             htrans;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [2:0]             hmaster;
    logic                   hmastlock;

    // Requester side: raises requests and transfer types, observes the grant.
    modport master (
        output hbusreq, hlock, hready, htrans,
        input  hgrant, hmaster, hmastlock
    );

    // Arbiter side: consumes requests, drives grant and address-phase owner.
    modport slave (
        input  hbusreq, hlock, hready, htrans,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter with lock, burst protection and a fairness hold limit.
// Latency: hgrant changes on the arbitration edge; hmaster/hmastlock follow one completed transfer later.
// Backpressure: with hready low every register holds, whatever the requests do.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic         hclk,
    input  logic         hreset,
    ahb_arbiter_if.slave bus
);
    localparam logic [1:0] PARK    = 2'd0;
    localparam logic [1:0] GRANTED = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam int            CW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [2:0]    DEF_IDX  = 3'(DEFAULT_MASTER);

    logic [1:0]    state, state_nxt;
    logic [2:0]    gidx, gidx_nxt, ptr, win;
    logic [2:0]    hmaster_q;
    logic          hmastlock_q;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    req8, lock8, owner8, others8, cand;
    logic          win_vld, trans_ok, owner_locked, arb_pt, hold_excl, competing;

    // Pad request vectors to 8 bits so a 3-bit index is always in range.
    assign req8    = 8'(bus.hbusreq);
    assign lock8   = 8'(bus.hlock);
    assign owner8  = 8'b0000_0001 << gidx;
    assign others8 = req8 & ~owner8;

    // IDLE and NONSEQ are the only legal boundaries; SEQ/BUSY are inside a burst.
    assign trans_ok     = ~bus.htrans[0];
    assign owner_locked = lock8[gidx] & req8[gidx];
    assign competing    = |others8;

    // LOCKED only reopens arbitration once the owner lets go of its lock request.
    assign arb_pt = bus.hready &
                    ((state == PARK) |
                     (trans_ok & ((state == GRANTED) | ((state == LOCKED) & ~owner_locked))));

    // An owner that used up its hold budget sits out one arbitration if someone else waits.
    assign hold_excl = (MAX_HOLD != 0) && (state == GRANTED) && (hold_cnt >= HOLD_MAX);
    assign cand      = (hold_excl && competing) ? others8 : req8;

    // Round-robin search starting one above the last winner.
    always_comb begin
        int         j;
        logic [2:0] jj;
        j       = 0;
        jj      = 3'd0;
        win     = gidx;
        win_vld = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j  = (int'(ptr) + i) % NUM_MASTERS;
            jj = 3'(j);
            if (!win_vld && cand[jj]) begin
                win_vld = 1'b1;
                win     = jj;
            end
        end
    end

    // Next grant and FSM state; only applied on an hready edge.
    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        if (arb_pt) begin
            if (win_vld) begin
                gidx_nxt  = win;
                state_nxt = lock8[win] ? LOCKED : GRANTED;
            end else begin
                gidx_nxt  = DEF_IDX;
                state_nxt = PARK;
            end
        end else if ((state == GRANTED) && owner_locked) begin
            state_nxt = LOCKED;
        end
    end

    // Grant, pointer, hold counter and address-phase owner registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= PARK;
            gidx        <= DEF_IDX;
            ptr         <= DEF_IDX;
            hold_cnt    <= '0;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else if (bus.hready) begin
            state       <= state_nxt;
            gidx        <= gidx_nxt;
            hmaster_q   <= gidx;
            hmastlock_q <= (state == LOCKED);
            if (arb_pt && win_vld && (win != gidx)) begin
                ptr <= win;
            end
            if ((gidx_nxt != gidx) || !competing) begin
                hold_cnt <= '0;
            end else if (bus.htrans[1] && (hold_cnt < HOLD_MAX)) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

    assign bus.hgrant    = NUM_MASTERS'(owner8);
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for the round-robin AHB arbiter, three masters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: hready is driven low in the wait-state section.
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    logic hclk = 1'b0;
    logic hreset;
    int   total = 0;
    int   bad   = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_if #(.NUM_MASTERS(3)) bus_a ();
    ahb_arbiter_if #(.NUM_MASTERS(3)) bus_b ();

    ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .MAX_HOLD(4)) u_dut_a (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_a)
    );

    ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .MAX_HOLD(2)) u_dut_b (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] lck,
                         input logic [1:0] tr, input logic rdy);
        bus_a.hbusreq = req;  bus_b.hbusreq = req;
        bus_a.hlock   = lck;  bus_b.hlock   = lck;
        bus_a.htrans  = tr;   bus_b.htrans  = tr;
        bus_a.hready  = rdy;  bus_b.hready  = rdy;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [1:0] beats [4];
        logic [2:0] eg;
        beats[0] = SEQ; beats[1] = BUSY; beats[2] = SEQ; beats[3] = SEQ;

        // Reset and park
        hreset = 1'b1;
        drive(3'b000, 3'b000, IDLE, 1'b1);
        step();
        step();
        hreset = 1'b0;
        check("rst_grant", 8'(bus_a.hgrant), 8'h01);
        check("rst_master", 8'(bus_a.hmaster), 8'h00);
        check("rst_lock", 8'(bus_a.hmastlock), 8'h00);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("park_grant%0d", k), 8'(bus_a.hgrant), 8'h01);
            check($sformatf("park_master%0d", k), 8'(bus_a.hmaster), 8'h00);
        end

        // Round robin: 0 parked, then 1,2,0,1,2,0; hmaster one transfer behind
        drive(3'b111, 3'b000, NONSEQ, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            eg = 3'b001 << (k % 3);
            check($sformatf("rr_grant%0d", k), 8'(bus_a.hgrant), 8'(eg));
            check($sformatf("rr_master%0d", k), 8'(bus_a.hmaster), 8'((k - 1) % 3));
        end

        // Wait states: master 1 owns, master 2 waits behind hready low
        drive(3'b010, 3'b000, NONSEQ, 1'b1);
        step();
        check("ws_grant_a", 8'(bus_a.hgrant), 8'h02);
        check("ws_master_a", 8'(bus_a.hmaster), 8'h00);
        step();
        check("ws_grant_b", 8'(bus_a.hgrant), 8'h02);
        check("ws_master_b", 8'(bus_a.hmaster), 8'h01);
        drive(3'b110, 3'b000, NONSEQ, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ws_hold_grant%0d", k), 8'(bus_a.hgrant), 8'h02);
            check($sformatf("ws_hold_master%0d", k), 8'(bus_a.hmaster), 8'h01);
        end
        drive(3'b110, 3'b000, NONSEQ, 1'b1);
        step();
        check("ws_switch_grant", 8'(bus_a.hgrant), 8'h04);
        check("ws_switch_master", 8'(bus_a.hmaster), 8'h01);
        drive(3'b100, 3'b000, NONSEQ, 1'b1);
        step();
        check("ws_after_master", 8'(bus_a.hmaster), 8'h02);

        // Burst protection: master 0 bursts while master 1 waits
        drive(3'b001, 3'b000, NONSEQ, 1'b1);
        step();
        check("bu_grant0", 8'(bus_a.hgrant), 8'h01);
        step();
        check("bu_master0", 8'(bus_a.hmaster), 8'h00);
        for (int k = 0; k < 4; k++) begin
            drive(3'b011, 3'b000, beats[k], 1'b1);
            step();
            check($sformatf("bu_beat_grant%0d", k), 8'(bus_a.hgrant), 8'h01);
        end
        drive(3'b011, 3'b000, IDLE, 1'b1);
        step();
        check("bu_end_grant", 8'(bus_a.hgrant), 8'h02);
        check("bu_end_master", 8'(bus_a.hmaster), 8'h00);

        // Lock on instance with MAX_HOLD=2
        hreset = 1'b1;
        drive(3'b000, 3'b000, IDLE, 1'b1);
        step();
        hreset = 1'b0;
        check("lk_rst_grant", 8'(bus_b.hgrant), 8'h01);
        drive(3'b010, 3'b010, NONSEQ, 1'b1);
        step();
        check("lk_start_grant", 8'(bus_b.hgrant), 8'h02);
        check("lk_start_lock", 8'(bus_b.hmastlock), 8'h00);
        drive(3'b011, 3'b010, NONSEQ, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("lk_grant%0d", k), 8'(bus_b.hgrant), 8'h02);
            check($sformatf("lk_master%0d", k), 8'(bus_b.hmaster), 8'h01);
            check($sformatf("lk_mastlock%0d", k), 8'(bus_b.hmastlock), 8'h01);
        end
        drive(3'b011, 3'b000, NONSEQ, 1'b1);
        step();
        check("lk_exit_grant", 8'(bus_b.hgrant), 8'h01);
        check("lk_exit_master", 8'(bus_b.hmaster), 8'h01);
        check("lk_exit_mastlock", 8'(bus_b.hmastlock), 8'h01);
        drive(3'b001, 3'b000, NONSEQ, 1'b1);
        step();
        check("lk_post_master", 8'(bus_b.hmaster), 8'h00);
        check("lk_post_mastlock", 8'(bus_b.hmastlock), 8'h00);

        // Hold limit on instance with MAX_HOLD=4, then mid-burst reset
        hreset = 1'b1;
        drive(3'b000, 3'b000, IDLE, 1'b1);
        step();
        hreset = 1'b0;
        drive(3'b100, 3'b000, NONSEQ, 1'b1);
        step();
        check("hl_m2_grant", 8'(bus_a.hgrant), 8'h04);
        drive(3'b000, 3'b000, IDLE, 1'b1);
        step();
        check("hl_park_grant", 8'(bus_a.hgrant), 8'h01);
        drive(3'b011, 3'b000, IDLE, 1'b1);
        step();
        check("hl_first_grant", 8'(bus_a.hgrant), 8'h01);
        drive(3'b011, 3'b000, NONSEQ, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("hl_keep_grant%0d", k), 8'(bus_a.hgrant), 8'h01);
        end
        step();
        check("hl_forced_grant", 8'(bus_a.hgrant), 8'h02);
        drive(3'b011, 3'b000, SEQ, 1'b1);
        step();
        check("hl_seq_grant", 8'(bus_a.hgrant), 8'h02);
        check("hl_seq_master", 8'(bus_a.hmaster), 8'h01);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        check("mr_grant", 8'(bus_a.hgrant), 8'h01);
        check("mr_master", 8'(bus_a.hmaster), 8'h00);
        check("mr_mastlock", 8'(bus_a.hmastlock), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
